nibble_word_assembler: RTL and testbench
========================================

Name: nibble_word_assembler

Overview:
- Receive side of the nibble-lane interface: accepts a stream of 4-bit nibbles and rebuilds full words, least-significant nibble first.
- Nibble k of a word lands in word bits [4k+3:4k], so for an 8-bit word the first nibble is bits [3:0] and the second is bits [7:4].
- Sits between the narrow nibble link and the byte/word datapath.
- Includes a small output FIFO so the link keeps streaming while the consumer stalls.

Parameters:
- NIBBLES, 2: nibbles per word; word width W = 4*NIBBLES; legal range 2..8.
- DEPTH, 2: output FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  Single clock; all state updates on the rising edge.
- rst_n  input  1  Asynchronous, active-low reset.
- in_valid  input  1  Nibble present on in_nibble.
- in_ready  output  1  Block can accept a nibble this cycle.
- in_nibble  input  4  Nibble data.
- in_last  input  1  Qualified by in_valid; this nibble closes the current word even if it is short.
- out_valid  output  1  out_word, out_partial and out_count hold a word.
- out_ready  input  1  Consumer takes the word this cycle.
- out_word  output  W  Assembled word; nibble positions never received read as 0.
- out_partial  output  1  Word was closed by in_last before NIBBLES nibbles arrived.
- out_count  output  $clog2(NIBBLES+1)  Number of valid nibbles in out_word (1..NIBBLES).
- overflow  output  1  Sticky error flag; cleared only by reset.

Behaviour:
- Handshakes: an input transfer is in_valid and in_ready in the same cycle; an output transfer is out_valid and out_ready in the same cycle.
  - Producer holds in_nibble and in_last stable while in_valid is high and in_ready is low.
  - Block holds out_word, out_partial and out_count stable while out_valid is high and out_ready is low.
- Reset (asynchronous assert, synchronous deassert by convention): in_ready=0 while rst_n is low, then 1 in the first cycle after release. out_valid=0, out_word=0, out_partial=0, out_count=0, overflow=0. Nibble index=0, accumulator=0, FIFO empty.
- Reset mid-word discards the partial word and all FIFO contents.
- Assembly state machine:
  - EMPTY (index 0): an input transfer writes bits [3:0] and sets index=1.
    - If in_last is high, or NIBBLES would be reached, the word closes immediately (see Close).
    - Otherwise go to COLLECT.
  - COLLECT (index k): an input transfer writes bits [4k+3:4k] and increments the index.
    - The word closes when the index reaches NIBBLES or in_last is high.
  - Close: push {accumulator with the new nibble merged, partial, count} into the FIFO in the same edge. Clear the accumulator and set index=0, returning to EMPTY.
- in_ready = FIFO not full, or FIFO full with an output transfer in the same cycle (pass-through of the pop).
  - Combinational only from out_ready and FIFO state; never from in_valid.
  - Gating applies to every nibble, not only the closing one, so no nibble is ever lost.
- Latency: the closing nibble's transfer at edge N makes out_valid=1 from edge N (visible in cycle N+1), provided the FIFO was empty.
- Throughput: with out_ready held high, one word per NIBBLES input cycles; no bubbles.
- Simultaneous push and pop:
  - Full FIFO: legal, occupancy unchanged.
  - Empty FIFO: the pop is not possible in that cycle; the word appears the next cycle.
- Output is registered from the FIFO head; there is no combinational in-to-out path.
- overflow is set if in_valid is high with in_ready low and in_nibble or in_last changes from the previous cycle (protocol violation). The data is still held and not lost.
- in_last on the final nibble of a full word: out_partial=0, out_count=NIBBLES.
- Pointer wrap: the read and write pointers carry one extra bit so full and empty are distinguished; wrap-around is tested explicitly.

Decomposition:
- Shared package nibble_lane_pkg:
  - NIBBLE_W=4.
  - Typedef nibble_t (logic [3:0]).
  - Function word_width(n)=4*n.
  - Packed struct asm_entry_t {partial, count, word}, parameterised via localparams in the module.
- One sub-module: nibble_fifo (DEPTH x entry width).
  - Ports push, pop, full, empty, head data.
  - Fully synchronous with the same clk/rst_n.
- Assembler FSM and accumulator stay in the top module.

Test Plan:
- Reset, then nibbles 0x5, 0xA with out_ready=1 -> one word, out_word=0xA5, out_count=2, out_partial=0; out_valid for exactly one cycle, one cycle after 0xA is accepted.
- NIBBLES=4: nibbles 0x1 then 0x2 with in_last=1 -> out_word=0x0021, out_count=2, out_partial=1; the next word starts at bits [3:0].
- DEPTH=2, out_ready=0, stream 6 nibbles -> two words queued (0x21, 0x43).
  - in_ready drops after the 4th nibble is accepted; the 5th is held.
  - Raise out_ready -> words 0x21, 0x43, 0x65 in order; none lost.
- out_ready toggling every cycle with a continuous 0x0..0xF nibble stream over 100+ words -> scoreboard matches order and data, and the FIFO pointers wrap several times.
- Assert rst_n low after a single 0x7 nibble with one word queued -> out_valid=0 immediately (asynchronous). After release, 0x3, 0x4 -> out_word=0x43 (stale 0x7 discarded).
- Hold in_valid with in_ready=0 and change in_nibble -> overflow=1 and stays set until reset.

Source files
------------

// File: rtl/nibble_lane_pkg.sv
// Shared definitions for the nibble-lane link.
//   NIBBLE_W    : width of one lane transfer
//   nibble_t    : one lane transfer
//   word_width  : word width in bits for a given nibble count
package nibble_lane_pkg;
  localparam int NIBBLE_W = 4;

  typedef logic [NIBBLE_W-1:0] nibble_t;

  function automatic int word_width(input int n);
    return NIBBLE_W * n;
  endfunction
endpackage

// File: rtl/nibble_word_assembler_if.sv
// Handshake bundle for the nibble word assembler.
//   in_valid/in_ready/in_nibble/in_last : nibble stream from the link
//   out_valid/out_ready/out_word/out_partial/out_count : assembled words
// master = producer/consumer side, slave = assembler side.
interface nibble_word_assembler_if #(parameter int NIBBLES = 2);
  import nibble_lane_pkg::*;

  localparam int W     = word_width(NIBBLES);
  localparam int CNT_W = $clog2(NIBBLES + 1);

  logic             in_valid;
  logic             in_ready;
  nibble_t          in_nibble;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_word;
  logic             out_partial;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_nibble, in_last, out_ready,
    input  in_ready, out_valid, out_word, out_partial, out_count
  );

  modport slave (
    input  in_valid, in_nibble, in_last, out_ready,
    output in_ready, out_valid, out_word, out_partial, out_count
  );
endinterface

// File: rtl/nibble_fifo.sv
// Small synchronous FIFO holding assembled word entries.
//   push/wdata : write an entry (ignored when full unless popping)
//   pop        : drop the head entry (ignored when empty)
//   full/empty : occupancy flags
//   head       : entry at the read pointer (undefined while empty)
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module nibble_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is fine when the head leaves on the same edge.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= wdata;
  end

  assign head = mem[rptr_q[AW-1:0]];
endmodule

// File: rtl/nibble_word_assembler.sv
// Rebuilds words from a 4-bit nibble stream, least-significant nibble first,
// and queues them in a small output FIFO.
//   clk, rst_n : clock, async active-low reset
//   bus        : nibble input and word output handshakes (slave side)
//   overflow   : sticky flag, set when a stalled producer changes its data
module nibble_word_assembler
  import nibble_lane_pkg::*;
#(
  parameter int NIBBLES = 2,
  parameter int DEPTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  nibble_word_assembler_if.slave bus,
  output logic                   overflow
);
  localparam int W     = word_width(NIBBLES);
  localparam int CNT_W = $clog2(NIBBLES + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIBBLES - 1);

  typedef struct packed {
    logic             partial;
    logic [CNT_W-1:0] count;
    logic [W-1:0]     word;
  } asm_entry_t;

  localparam int ENTRY_W = $bits(asm_entry_t);

  typedef enum logic {S_EMPTY, S_COLLECT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d, cur_idx;
  logic [W-1:0]     acc_q, acc_d, merged;
  logic             rdy_en, rdy, full, empty, pop, push, in_xfer, close;
  logic             stall_q, prev_last_q;
  nibble_t          prev_nib_q;
  asm_entry_t       wr_entry, head;

  // Holds in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  assign pop     = ~empty & bus.out_ready;
  assign rdy     = rdy_en & (~full | pop);
  assign in_xfer = bus.in_valid & rdy;
  assign cur_idx = (state_q == S_EMPTY) ? '0 : idx_q;
  assign close   = bus.in_last | (cur_idx == LAST_IDX);
  assign push    = in_xfer & close;

  always_comb begin
    merged = acc_q;
    for (int k = 0; k < NIBBLES; k++)
      if (cur_idx == CNT_W'(k)) merged[k*NIBBLE_W +: NIBBLE_W] = bus.in_nibble;
  end

  always_comb begin
    wr_entry.word    = merged;
    wr_entry.count   = cur_idx + CNT_W'(1);
    wr_entry.partial = (cur_idx != LAST_IDX);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    if (in_xfer) begin
      if (close) begin
        state_d = S_EMPTY;
        idx_d   = '0;
        acc_d   = '0;
      end else begin
        state_d = S_COLLECT;
        idx_d   = cur_idx + CNT_W'(1);
        acc_d   = merged;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      idx_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end

  // Protocol watch: data must not move while a transfer is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q     <= 1'b0;
      prev_nib_q  <= '0;
      prev_last_q <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      stall_q     <= bus.in_valid & ~rdy;
      prev_nib_q  <= bus.in_nibble;
      prev_last_q <= bus.in_last;
      if (bus.in_valid && !rdy && stall_q &&
          ((bus.in_nibble != prev_nib_q) || (bus.in_last != prev_last_q)))
        overflow <= 1'b1;
    end
  end

  nibble_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign bus.in_ready    = rdy;
  assign bus.out_valid   = ~empty;
  assign bus.out_word    = empty ? '0 : head.word;
  assign bus.out_count   = empty ? '0 : head.count;
  assign bus.out_partial = ~empty & head.partial;
endmodule

// File: tb/tb_nibble_word_assembler.sv
module tb_nibble_word_assembler;
  logic clk = 1'b0;
  logic rst_n;
  logic ovf2, ovf4;
  always #5 clk = ~clk;

  nibble_word_assembler_if #(.NIBBLES(2)) bus2();
  nibble_word_assembler_if #(.NIBBLES(4)) bus4();

  nibble_word_assembler #(.NIBBLES(2), .DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .overflow(ovf2));
  nibble_word_assembler #(.NIBBLES(4), .DEPTH(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .overflow(ovf4));

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       iv;
    logic [3:0] nib;
    logic       last;
    logic       ev;
    logic [7:0] ew;
    logic [1:0] ec;
    logic       ep;
  } vec_t;
  vec_t vt[10];

  // {5'b0, partial, count, word} for the NIBBLES=2 instance
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  logic        mon_en = 1'b0;

  always @(negedge clk)
    if (mon_en && bus2.out_valid && bus2.out_ready)
      got_q.push_back({5'b0, bus2.out_partial, bus2.out_count, bus2.out_word});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: no handshake within cycle budget", name);
  endtask

  // Drive a nibble at posedge+1 and return #1 after the edge that took it.
  task automatic send2(input logic [3:0] nib, input logic last);
    bit acc;
    bus2.in_valid = 1'b1; bus2.in_nibble = nib; bus2.in_last = last;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk); acc = bus2.in_ready;
      @(posedge clk); #1;
      if (acc) return;
    end
    timeout("send2");
  endtask

  task automatic send4(input logic [3:0] nib, input logic last);
    bit acc;
    bus4.in_valid = 1'b1; bus4.in_nibble = nib; bus4.in_last = last;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk); acc = bus4.in_ready;
      @(posedge clk); #1;
      if (acc) return;
    end
    timeout("send4");
  endtask

  task automatic idle2(input int n);
    bus2.in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic compare_queues(input string name);
    chk({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_word%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] low;
    bit acc;
    int nacc;

    vt[0] = '{1'b1, 4'h5, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0};
    vt[1] = '{1'b1, 4'hA, 1'b0, 1'b1, 8'hA5, 2'd2, 1'b0};
    vt[2] = '{1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0};
    vt[3] = '{1'b1, 4'h3, 1'b1, 1'b1, 8'h03, 2'd1, 1'b1};
    vt[4] = '{1'b1, 4'hC, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0};
    vt[5] = '{1'b1, 4'hD, 1'b1, 1'b1, 8'hDC, 2'd2, 1'b0};
    vt[6] = '{1'b1, 4'hF, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0};
    vt[7] = '{1'b1, 4'h0, 1'b0, 1'b1, 8'h0F, 2'd2, 1'b0};
    vt[8] = '{1'b1, 4'h1, 1'b1, 1'b1, 8'h01, 2'd1, 1'b1};
    vt[9] = '{1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0};

    rst_n = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_nibble = '0; bus2.in_last = 1'b0; bus2.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.in_nibble = '0; bus4.in_last = 1'b0; bus4.out_ready = 1'b1;

    // Reset state
    #22;
    chk("rst_in_ready",  32'(bus2.in_ready),    0);
    chk("rst_out_valid", 32'(bus2.out_valid),   0);
    chk("rst_out_word",  32'(bus2.out_word),    0);
    chk("rst_out_count", 32'(bus2.out_count),   0);
    chk("rst_partial",   32'(bus2.out_partial), 0);
    chk("rst_overflow",  32'(ovf2),             0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", 32'(bus2.in_ready), 1);

    // Table-driven stream with out_ready held high
    for (int i = 0; i < 10; i++) begin
      if (vt[i].iv) send2(vt[i].nib, vt[i].last);
      else          idle2(1);
      chk($sformatf("vec%0d_valid", i), 32'(bus2.out_valid), 32'(vt[i].ev));
      chk($sformatf("vec%0d_word", i),  32'(bus2.out_word),  32'(vt[i].ew));
      chk($sformatf("vec%0d_ready", i), 32'(bus2.in_ready),  1);
      if (vt[i].ev) begin
        chk($sformatf("vec%0d_count", i),   32'(bus2.out_count),   32'(vt[i].ec));
        chk($sformatf("vec%0d_partial", i), 32'(bus2.out_partial), 32'(vt[i].ep));
      end
    end

    // NIBBLES=4: short word, then a full word starting at bits [3:0]
    send4(4'h1, 1'b0);
    send4(4'h2, 1'b1);
    chk("n4_short_valid",   32'(bus4.out_valid),   1);
    chk("n4_short_word",    32'(bus4.out_word),    32'h0021);
    chk("n4_short_count",   32'(bus4.out_count),   2);
    chk("n4_short_partial", 32'(bus4.out_partial), 1);
    send4(4'h3, 1'b0);
    chk("n4_mid_valid", 32'(bus4.out_valid), 0);
    send4(4'h4, 1'b0);
    send4(4'h5, 1'b0);
    send4(4'h6, 1'b0);
    bus4.in_valid = 1'b0;
    chk("n4_full_word",    32'(bus4.out_word),    32'h6543);
    chk("n4_full_count",   32'(bus4.out_count),   4);
    chk("n4_full_partial", 32'(bus4.out_partial), 0);

    // Backpressure: two words fill the FIFO, the 5th nibble is held
    bus2.out_ready = 1'b0;
    send2(4'h1, 1'b0); send2(4'h2, 1'b0);
    send2(4'h3, 1'b0); send2(4'h4, 1'b0);
    chk("bp_in_ready_full", 32'(bus2.in_ready), 0);
    chk("bp_head_word",     32'(bus2.out_word), 32'h21);
    bus2.in_valid = 1'b1; bus2.in_nibble = 4'h5; bus2.in_last = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("bp_held_ready", 32'(bus2.in_ready), 0);
    chk("bp_held_word",  32'(bus2.out_word), 32'h21);
    chk("bp_no_overflow", 32'(ovf2), 0);
    got_q.delete(); exp_q.delete();
    exp_q.push_back({5'b0, 1'b0, 2'd2, 8'h21});
    exp_q.push_back({5'b0, 1'b0, 2'd2, 8'h43});
    exp_q.push_back({5'b0, 1'b0, 2'd2, 8'h65});
    mon_en = 1'b1;
    bus2.out_ready = 1'b1;
    send2(4'h5, 1'b0);
    send2(4'h6, 1'b0);
    idle2(6);
    mon_en = 1'b0;
    compare_queues("bp");

    // Continuous 0..F stream, out_ready toggling, 200 words through DEPTH=2
    got_q.delete(); exp_q.delete();
    mon_en = 1'b1;
    bus2.out_ready = 1'b0;
    low = '0;
    for (int n = 0; n < 400; n++) begin
      bus2.in_valid = 1'b1; bus2.in_nibble = 4'(n); bus2.in_last = 1'b0;
      acc = 1'b0;
      nacc = 0;
      while (!acc && nacc < 32) begin
        @(negedge clk); acc = bus2.in_ready;
        @(posedge clk); #1;
        bus2.out_ready = ~bus2.out_ready;
        nacc++;
      end
      if (!acc) begin
        timeout("stream");
        break;
      end
      if (n % 2 == 0) low = 4'(n);
      else exp_q.push_back({5'b0, 1'b0, 2'd2, 4'(n), low});
    end
    bus2.in_valid = 1'b0;
    bus2.out_ready = 1'b1;
    idle2(6);
    mon_en = 1'b0;
    compare_queues("stream");
    chk("stream_overflow", 32'(ovf2), 0);

    // Reset with one word queued and 0x7 half-assembled
    bus2.out_ready = 1'b0;
    send2(4'h1, 1'b0); send2(4'h2, 1'b0);
    send2(4'h7, 1'b0);
    bus2.in_valid = 1'b0;
    chk("pre_rst_valid", 32'(bus2.out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus2.out_valid), 0);
    chk("async_rst_ready", 32'(bus2.in_ready),  0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(bus2.in_ready),  1);
    chk("post_rst_valid", 32'(bus2.out_valid), 0);
    bus2.out_ready = 1'b1;
    send2(4'h3, 1'b0);
    chk("post_rst_first_valid", 32'(bus2.out_valid), 0);
    send2(4'h4, 1'b0);
    bus2.in_valid = 1'b0;
    chk("post_rst_word_valid", 32'(bus2.out_valid), 1);
    chk("post_rst_word",       32'(bus2.out_word),  32'h43);
    chk("post_rst_count",      32'(bus2.out_count), 2);
    idle2(1);

    // Protocol violation: stalled producer changes its nibble
    bus2.out_ready = 1'b0;
    send2(4'h1, 1'b0); send2(4'h2, 1'b0);
    send2(4'h3, 1'b0); send2(4'h4, 1'b0);
    bus2.in_valid = 1'b1; bus2.in_nibble = 4'h8; bus2.in_last = 1'b0;
    @(posedge clk); #1;
    chk("ovf_before_change", 32'(ovf2), 0);
    bus2.in_nibble = 4'h9;
    @(posedge clk); #1;
    chk("ovf_set", 32'(ovf2), 1);
    idle2(3);
    chk("ovf_sticky", 32'(ovf2), 1);
    chk("ovf_head_kept", 32'(bus2.out_word), 32'h21);
    rst_n = 1'b0;
    #1;
    chk("ovf_cleared", 32'(ovf2), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
